// File: rtl/axi4_256_to_avmm.sv
// AXI4 subordinate to 256-bit Avalon-MM bursting host. Reads and writes share one
// Avalon port via round-robin; a read-data FIFO absorbs rready backpressure.
module axi4_256_to_avmm #(
  parameter int RD_FIFO_DEPTH      = 256,
  parameter int RD_MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [35:0]  s0_araddr,
  input  logic         s0_arid,
  input  logic [7:0]   s0_arlen,
  input  logic [2:0]   s0_arsize,
  input  logic [1:0]   s0_arburst,
  input  logic         s0_arvalid,
  output logic         s0_arready,
  output logic [255:0] s0_rdata,
  output logic         s0_rid,
  output logic [1:0]   s0_rresp,
  output logic         s0_rlast,
  output logic         s0_rvalid,
  input  logic         s0_rready,
  input  logic [35:0]  s0_awaddr,
  input  logic         s0_awid,
  input  logic [7:0]   s0_awlen,
  input  logic [2:0]   s0_awsize,
  input  logic [1:0]   s0_awburst,
  input  logic         s0_awvalid,
  output logic         s0_awready,
  input  logic [255:0] s0_wdata,
  input  logic [31:0]  s0_wstrb,
  input  logic         s0_wlast,
  input  logic         s0_wvalid,
  output logic         s0_wready,
  output logic         s0_bid,
  output logic [1:0]   s0_bresp,
  output logic         s0_bvalid,
  input  logic         s0_bready,
  output logic [35:0]  m0_address,
  output logic [7:0]   m0_burstcount,
  output logic [31:0]  m0_byteenable,
  output logic         m0_read,
  output logic         m0_write,
  output logic [255:0] m0_writedata,
  input  logic [255:0] m0_readdata,
  input  logic         m0_readdatavalid,
  input  logic         m0_waitrequest
);
  localparam int CW  = $clog2(RD_FIFO_DEPTH + 1);
  localparam int DAW = $clog2(RD_FIFO_DEPTH);
  localparam int CAW = (RD_MAX_OUTSTANDING > 1) ? $clog2(RD_MAX_OUTSTANDING) : 1;
  localparam int CCW = $clog2(RD_MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_DATA, WR_RESP} state_t;

  state_t          r_state;
  logic [35:0]     r_addr;
  logic [7:0]      r_len, r_bcnt, r_wbeat, r_rbeat;
  logic            r_id, r_last_wr, r_arready, r_awready, r_werr;
  logic [CW-1:0]   r_credit, r_dcnt;
  logic [255:0]    r_dmem [RD_FIFO_DEPTH];
  logic [DAW-1:0]  r_dwp, r_drp;
  logic [8:0]      r_cmem [RD_MAX_OUTSTANDING];
  logic [CAW-1:0]  r_cwp, r_crp;
  logic [CCW-1:0]  r_ccnt;

  logic [CW-1:0]   w_need, w_debit;
  logic            w_rd_elig, w_gnt_rd, w_gnt_wr, w_rd_issue, w_wbeat, w_rpop, w_wlast_beat;
  logic            w_unused;

  assign w_unused = ^{s0_arsize, s0_arburst, s0_awsize, s0_awburst};

  // Credit tracks data-FIFO slots not yet promised to an issued read burst.
  assign w_need       = CW'({1'b0, s0_arlen}) + CW'(1);
  assign w_rd_elig    = s0_arvalid && (r_credit >= w_need) && (r_ccnt != CCW'(RD_MAX_OUTSTANDING));
  assign w_gnt_rd     = (r_state == IDLE) && w_rd_elig && (!s0_awvalid || r_last_wr);
  assign w_gnt_wr     = (r_state == IDLE) && s0_awvalid && !w_gnt_rd;
  assign w_rd_issue   = (r_state == RD_CMD) && !m0_waitrequest;
  assign w_wbeat      = (r_state == WR_DATA) && s0_wvalid && !m0_waitrequest;
  assign w_wlast_beat = (r_wbeat == r_len);
  assign w_rpop       = s0_rvalid && s0_rready;
  assign w_debit      = w_rd_issue ? (CW'({1'b0, r_len}) + CW'(1)) : '0;

  assign s0_arready    = r_arready;
  assign s0_awready    = r_awready;
  assign m0_read       = (r_state == RD_CMD);
  assign m0_write      = (r_state == WR_DATA) && s0_wvalid;
  assign s0_wready     = (r_state == WR_DATA) && !m0_waitrequest;
  assign m0_address    = r_addr;
  assign m0_burstcount = r_bcnt;
  assign m0_writedata  = s0_wdata;
  assign m0_byteenable = s0_wstrb;
  assign s0_bvalid     = (r_state == WR_RESP);
  assign s0_bid        = r_id;
  assign s0_bresp      = r_werr ? 2'b10 : 2'b00;
  assign s0_rvalid     = (r_dcnt != '0);
  assign s0_rdata      = r_dmem[r_drp];
  assign s0_rid        = r_cmem[r_crp][8];
  assign s0_rlast      = s0_rvalid && (r_rbeat == r_cmem[r_crp][7:0]);
  assign s0_rresp      = 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_bcnt    <= '0;
      r_id      <= 1'b0;
      r_last_wr <= 1'b1;
      r_arready <= 1'b0;
      r_awready <= 1'b0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
    end else begin
      r_arready <= 1'b0;
      r_awready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_rd) begin
            r_arready <= 1'b1;
            r_addr    <= s0_araddr;
            r_len     <= s0_arlen;
            r_bcnt    <= s0_arlen + 8'd1;
            r_id      <= s0_arid;
            r_last_wr <= 1'b0;
            r_state   <= RD_CMD;
          end else if (w_gnt_wr) begin
            r_awready <= 1'b1;
            r_addr    <= s0_awaddr;
            r_len     <= s0_awlen;
            r_bcnt    <= s0_awlen + 8'd1;
            r_id      <= s0_awid;
            r_last_wr <= 1'b1;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_state   <= WR_DATA;
          end
        end
        RD_CMD: if (!m0_waitrequest) r_state <= IDLE;
        WR_DATA: if (w_wbeat) begin
          // Beat count alone ends the burst; a misplaced wlast only flags SLVERR.
          r_wbeat <= r_wbeat + 8'd1;
          if (s0_wlast != w_wlast_beat) r_werr <= 1'b1;
          if (w_wlast_beat) r_state <= WR_RESP;
        end
        WR_RESP: if (s0_bready) begin
          r_werr  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit <= CW'(RD_FIFO_DEPTH);
      r_dcnt   <= '0;
      r_dwp    <= '0;
      r_drp    <= '0;
      r_cwp    <= '0;
      r_crp    <= '0;
      r_ccnt   <= '0;
      r_rbeat  <= '0;
    end else begin
      r_credit <= r_credit - w_debit + (w_rpop ? CW'(1) : CW'(0));
      r_dcnt   <= r_dcnt + (m0_readdatavalid ? CW'(1) : CW'(0)) - (w_rpop ? CW'(1) : CW'(0));
      if (m0_readdatavalid) r_dwp <= (r_dwp == DAW'(RD_FIFO_DEPTH - 1)) ? '0 : r_dwp + DAW'(1);
      if (w_rpop) begin
        r_drp   <= (r_drp == DAW'(RD_FIFO_DEPTH - 1)) ? '0 : r_drp + DAW'(1);
        r_rbeat <= s0_rlast ? '0 : r_rbeat + 8'd1;
      end
      if (w_rd_issue) r_cwp <= (r_cwp == CAW'(RD_MAX_OUTSTANDING - 1)) ? '0 : r_cwp + CAW'(1);
      if (w_rpop && s0_rlast) r_crp <= (r_crp == CAW'(RD_MAX_OUTSTANDING - 1)) ? '0 : r_crp + CAW'(1);
      r_ccnt <= r_ccnt + (w_rd_issue ? CCW'(1) : CCW'(0)) - ((w_rpop && s0_rlast) ? CCW'(1) : CCW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (m0_readdatavalid) r_dmem[r_dwp] <= m0_readdata;
    if (w_rd_issue) r_cmem[r_cwp] <= {r_id, r_len};
  end
endmodule

// File: tb/tb_axi4_256_to_avmm.sv
// Directed bench for axi4_256_to_avmm with a small Avalon agent model.
module tb_axi4_256_to_avmm;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [35:0] s0_araddr, s0_awaddr, m0_address;
  logic s0_arid, s0_awid, s0_arvalid, s0_arready, s0_awvalid, s0_awready;
  logic [7:0] s0_arlen, s0_awlen, m0_burstcount;
  logic [2:0] s0_arsize, s0_awsize;
  logic [1:0] s0_arburst, s0_awburst, s0_rresp, s0_bresp;
  logic [255:0] s0_rdata, s0_wdata, m0_writedata, m0_readdata;
  logic s0_rid, s0_rlast, s0_rvalid, s0_rready;
  logic [31:0] s0_wstrb, m0_byteenable;
  logic s0_wlast, s0_wvalid, s0_wready, s0_bid, s0_bvalid, s0_bready;
  logic m0_read, m0_write, m0_readdatavalid, m0_waitrequest;

  axi4_256_to_avmm #(.RD_FIFO_DEPTH(256), .RD_MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awid(s0_awid), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
    .s0_wready(s0_wready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .m0_address(m0_address), .m0_burstcount(m0_burstcount),
    .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest)
  );

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rd_pat(input logic [35:0] a, input int b);
    return {{24{8'hAA}}, a[31:0], 32'(b)};
  endfunction
  function automatic logic [255:0] wr_pat(input logic [35:0] a, input int b);
    return {{24{8'h55}}, a[31:0], 32'(b)};
  endfunction
  function automatic logic [31:0] strb_pat(input int b);
    return 32'hF0F0_0000 | 32'(b);
  endfunction

  // Avalon agent: acts 2 time units after each rising edge, returns read data 3 cycles late.
  typedef struct { logic [255:0] d; int due; } pend_t;
  typedef struct { logic [35:0] a; logic [7:0] bc; logic [255:0] d; logic [31:0] be; } wlog_t;
  pend_t rq[$];
  wlog_t wlog[$];
  int cyc = 0, n_rdv = 0;
  logic wr_toggle = 1'b0;
  logic [7:0] last_rd_bc = 8'hFF;

  initial begin m0_readdatavalid = 1'b0; m0_waitrequest = 1'b0; m0_readdata = '0; end

  always @(posedge clk) begin
    logic w;
    int n;
    #2;
    cyc++;
    if (reset) begin
      rq.delete();
      m0_readdatavalid = 1'b0;
      m0_waitrequest = 1'b0;
    end else begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        m0_readdatavalid = 1'b1;
        m0_readdata = rq[0].d;
        void'(rq.pop_front());
        n_rdv++;
      end else m0_readdatavalid = 1'b0;
      w = wr_toggle && (cyc % 2 == 1);
      m0_waitrequest = w;
      if (m0_read && !w) begin
        last_rd_bc = m0_burstcount;
        n = (m0_burstcount == 8'd0) ? 256 : int'(m0_burstcount);
        for (int i = 0; i < n; i++) rq.push_back('{rd_pat(m0_address, i), cyc + 3 + i});
      end
      if (m0_write && !w) wlog.push_back('{m0_address, m0_burstcount, m0_writedata, m0_byteenable});
    end
  end

  typedef struct { logic [255:0] d; logic id; logic last; logic [1:0] resp; } rb_t;
  rb_t rbq[$];
  logic [2:0] bq[$];
  logic glog[$];
  always @(negedge clk) if (!reset) begin
    if (s0_rvalid && s0_rready) rbq.push_back('{s0_rdata, s0_rid, s0_rlast, s0_rresp});
    if (s0_bvalid && s0_bready) bq.push_back({s0_bid, s0_bresp});
    if (s0_arready) glog.push_back(1'b0);
    if (s0_awready) glog.push_back(1'b1);
  end

  task automatic ar_hs(input logic [35:0] a, input logic [7:0] len, input logic id);
    int k;
    @(posedge clk); #1;
    s0_araddr = a; s0_arlen = len; s0_arid = id; s0_arvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!s0_arready && k < 400);
    if (!s0_arready) check("ar_timeout", 0, 1);
    @(posedge clk); #1 s0_arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [35:0] a, input logic [7:0] len, input logic id);
    int k;
    @(posedge clk); #1;
    s0_awaddr = a; s0_awlen = len; s0_awid = id; s0_awvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!s0_awready && k < 400);
    if (!s0_awready) check("aw_timeout", 0, 1);
    @(posedge clk); #1 s0_awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [35:0] a, input int len, input int bad);
    int k;
    for (int i = 0; i <= len; i++) begin
      @(posedge clk); #1;
      s0_wvalid = 1'b1; s0_wdata = wr_pat(a, i); s0_wstrb = strb_pat(i);
      s0_wlast = (i == len) || (i == bad);
      k = 0;
      do begin @(negedge clk); k++; end while (!s0_wready && k < 400);
      if (!s0_wready) check("w_timeout", 0, 1);
    end
    @(posedge clk); #1 s0_wvalid = 1'b0; s0_wlast = 1'b0;
    k = 0;
    while (!s0_bvalid && k < 100) begin @(negedge clk); k++; end
    if (!s0_bvalid) check("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic [35:0] a, input logic [7:0] len, input logic id, input int bad);
    fork
      aw_hs(a, len, id);
      w_beats(a, int'(len), bad);
    join
  endtask

  task automatic wait_rb(input int n);
    int k = 0;
    while (rbq.size() < n && k < 2000) begin @(negedge clk); k++; end
    if (rbq.size() < n) check("rbeat_timeout", 32'(rbq.size()), 32'(n));
  endtask

  function automatic logic [255:0] outs_vec();
    return {s0_arready, s0_awready, s0_wready, s0_rvalid, s0_bvalid, m0_read, m0_write,
            s0_rlast, m0_burstcount, m0_address};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad, g, d0;
    s0_araddr = '0; s0_arid = 0; s0_arlen = 0; s0_arsize = 3'd5; s0_arburst = 2'd1; s0_arvalid = 0;
    s0_awaddr = '0; s0_awid = 0; s0_awlen = 0; s0_awsize = 3'd5; s0_awburst = 2'd1; s0_awvalid = 0;
    s0_wdata = '0; s0_wstrb = '0; s0_wlast = 0; s0_wvalid = 0; s0_rready = 1; s0_bready = 1;
    #12 check("reset_outs", outs_vec(), '0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single-beat read
    ar_hs(36'h100, 8'd0, 1'b1);
    wait_rb(1);
    repeat (3) @(negedge clk);
    check("rd1_count", 32'(rbq.size()), 32'd1);
    check("rd1_data", rbq[0].d, {{24{8'hAA}}, 32'h100, 32'h0});
    check("rd1_last", rbq[0].last, 1'b1);
    check("rd1_resp", rbq[0].resp, 2'b00);
    check("rd1_id", rbq[0].id, 1'b1);
    check("rd1_bc", last_rd_bc, 8'd1);
    rbq.delete();

    // 256-beat read against held rready
    s0_rready = 1'b0;
    d0 = n_rdv;
    ar_hs(36'h1000, 8'd255, 1'b0);
    @(posedge clk); #1;
    s0_araddr = 36'h9000; s0_arlen = 8'd0; s0_arid = 1'b1; s0_arvalid = 1'b1;
    g = 0;
    repeat (300) begin @(negedge clk); if (s0_arready) g++; end
    check("full_no_grant", 32'(g), 32'd0);
    check("full_beats_in", 32'(n_rdv - d0), 32'd256);
    check("full_rvalid", s0_rvalid, 1'b1);
    check("bc256_enc", last_rd_bc, 8'h00);
    @(posedge clk); #1 s0_arvalid = 1'b0; s0_rready = 1'b1;
    wait_rb(256);
    nbad = 0;
    for (int i = 0; i < 256 && i < rbq.size(); i++)
      if (rbq[i].d !== rd_pat(36'h1000, i) || rbq[i].last !== (i == 255) || rbq[i].id !== 1'b0) nbad++;
    check("r256_beats_bad", 32'(nbad), 32'd0);
    repeat (5) @(negedge clk);
    check("r256_count", 32'(rbq.size()), 32'd256);
    rbq.delete();

    // Write with toggling waitrequest
    wr_toggle = 1'b1;
    wlog.delete(); bq.delete();
    wr_burst(36'h2000, 8'd3, 1'b1, -1);
    check("wr_beats", 32'(wlog.size()), 32'd4);
    nbad = 0;
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      if (wlog[i].a !== 36'h2000 || wlog[i].bc !== 8'd4 || wlog[i].d !== wr_pat(36'h2000, i) ||
          wlog[i].be !== strb_pat(i)) nbad++;
    check("wr_beats_bad", 32'(nbad), 32'd0);
    check("wr_b", (bq.size() == 1) ? bq[0] : 3'b111, {1'b1, 2'b00});

    // Early wlast still yields full burst and SLVERR
    wlog.delete(); bq.delete();
    wr_burst(36'h2400, 8'd3, 1'b0, 1);
    check("wrerr_beats", 32'(wlog.size()), 32'd4);
    check("wrerr_b", (bq.size() == 1) ? bq[0] : 3'b111, {1'b0, 2'b10});
    wr_toggle = 1'b0;

    // Simultaneous AR/AW alternate
    glog.delete(); bq.delete(); rbq.delete();
    for (int k = 0; k < 3; k++) begin
      fork
        ar_hs(36'h3000 + 36'(k * 256), 8'd1, 1'(k));
        wr_burst(36'h4000 + 36'(k * 256), 8'd1, ~1'(k), -1);
      join
    end
    wait_rb(6);
    g = 0;
    for (int i = 0; i < glog.size() && i < 6; i++) g[i] = glog[i];
    check("rr_order", {32'(glog.size()), 32'(g)}, {32'd6, 32'b101010});
    nbad = 0;
    for (int j = 0; j < 6 && j < rbq.size(); j++)
      if (rbq[j].d !== rd_pat(36'h3000 + 36'((j / 2) * 256), j % 2) || rbq[j].last !== (j % 2 == 1) ||
          rbq[j].id !== 1'(j / 2)) nbad++;
    check("rr_rdata_bad", 32'(nbad), 32'd0);
    check("rr_b", {32'(bq.size()), bq[0], bq[1], bq[2]}, {32'd3, 3'b100, 3'b000, 3'b100});

    // Reset in the middle of a write burst
    aw_hs(36'h5000, 8'd7, 1'b1);
    s0_wvalid = 1'b1; s0_wdata = wr_pat(36'h5000, 0); s0_wstrb = '1; s0_wlast = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wr_active", m0_write, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    #1 check("mid_reset_outs", outs_vec(), '0);
    s0_wvalid = 1'b0;
    @(negedge clk); @(negedge clk) reset = 1'b0;
    rbq.delete();
    ar_hs(36'h500, 8'd0, 1'b0);
    wait_rb(1);
    check("post_rst_data", (rbq.size() > 0) ? rbq[0].d : '0, rd_pat(36'h500, 0));
    check("post_rst_last", (rbq.size() > 0) ? rbq[0].last : 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
